// File: rtl/aur_ll_tx_framer_if.sv
// Interfaces for aur_ll_tx_framer: the NetFPGA 64-bit datapath input bus and the
// Aurora LocalLink TX bus. "master" drives the data, "slave" returns the ready.
interface aur_ll_tx_dp_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] in_data;
  logic [CTRL_WIDTH-1:0] in_ctrl;
  logic                  in_wr;
  logic                  in_rdy;

  modport master (output in_data, output in_ctrl, output in_wr, input in_rdy);
  modport slave  (input in_data, input in_ctrl, input in_wr, output in_rdy);
endinterface

interface aur_ll_tx_framer_if;
  logic [0:15] tx_d;
  logic        tx_rem;
  logic        tx_src_rdy_n;
  logic        tx_sof_n;
  logic        tx_eof_n;
  logic        tx_dst_rdy_n;

  modport master (output tx_d, output tx_rem, output tx_src_rdy_n, output tx_sof_n,
                  output tx_eof_n, input tx_dst_rdy_n);
  modport slave  (input tx_d, input tx_rem, input tx_src_rdy_n, input tx_sof_n,
                  input tx_eof_n, output tx_dst_rdy_n);
endinterface

// File: rtl/aur_ll_tx_framer.sv
// NetFPGA 64-bit datapath to 16-bit Aurora LocalLink TX framer.
// Define AUR_TX_STATS_EN to build the tx_frame_cnt / tx_abort_cnt counters.
module aur_ll_tx_framer #(
  parameter int                   DATA_WIDTH = 64,
  parameter int                   CTRL_WIDTH = DATA_WIDTH / 8,
  parameter logic [CTRL_WIDTH-1:0] HDR_CTRL  = 8'hFF
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      channel_up,
  aur_ll_tx_dp_if.slave             dp,
  aur_ll_tx_framer_if.master        ll,
  output logic [15:0]               tx_frame_cnt,
  output logic [15:0]               tx_abort_cnt
);

  localparam int WORD_W = DATA_WIDTH + CTRL_WIDTH;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [WORD_W-1:0]     mem [2];
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            count, count_nx;
  logic                  in_rdy_q;
  logic                  push, pop;

  logic [WORD_W-1:0]     head;
  logic [DATA_WIDTH-1:0] head_data;
  logic [CTRL_WIDTH-1:0] head_ctrl;
  logic                  head_valid, is_hdr, is_end;
  logic [3:0]            end_bytes;
  logic [1:0]            last_beat;

  logic [1:0]            state, state_nx;
  logic [1:0]            beat, beat_nx;
  logic                  sof_pend, sof_pend_nx;
  logic                  active, xfer, last, sof;
  logic [15:0]           lane;

  assign head       = mem[rd_ptr];
  assign head_data  = head[DATA_WIDTH-1:0];
  assign head_ctrl  = head[WORD_W-1:DATA_WIDTH];
  assign head_valid = (count != 2'd0);
  assign is_hdr     = (head_ctrl == HDR_CTRL);
  assign is_end     = (head_ctrl != '0) && !is_hdr;

  assign push      = dp.in_wr && in_rdy_q;
  assign count_nx  = count + {1'b0, push} - {1'b0, pop};
  assign dp.in_rdy = in_rdy_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem[0]   <= '0;
      mem[1]   <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      in_rdy_q <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {dp.in_ctrl, dp.in_data};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count    <= count_nx;
      in_rdy_q <= (count_nx != 2'd2);
    end
  end

  // The lowest set ctrl bit marks the last valid byte; scanning high-to-low lets it win.
  always_comb begin
    end_bytes = 4'd8;
    for (int i = CTRL_WIDTH - 1; i >= 0; i--) begin
      if (head_ctrl[i]) end_bytes = 4'(CTRL_WIDTH - i);
    end
    last_beat = is_end ? 2'((end_bytes - 4'd1) >> 1) : 2'd3;
  end

  always_comb begin
    case (beat)
      2'd0:    lane = head_data[63:48];
      2'd1:    lane = head_data[47:32];
      2'd2:    lane = head_data[31:16];
      default: lane = head_data[15:0];
    endcase
  end

  // IDLE presents beat 0 directly so a buffered frame starts the cycle after the last EOF.
  assign active = head_valid && channel_up &&
                  ((state == ST_SEND) || ((state == ST_IDLE) && !is_hdr));
  assign xfer   = active && !ll.tx_dst_rdy_n;
  assign last   = (beat == last_beat);
  assign sof    = sof_pend || (state == ST_IDLE);

  always_comb begin
    state_nx    = state;
    beat_nx     = beat;
    sof_pend_nx = sof_pend;
    pop         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (head_valid) begin
          if (is_hdr) begin
            pop = 1'b1;
          end else if (!channel_up) begin
            pop = 1'b1;
            if (!is_end) state_nx = ST_DROP;
          end else begin
            state_nx    = ST_SEND;
            beat_nx     = 2'd0;
            sof_pend_nx = 1'b1;
          end
        end
      end
      ST_SEND: begin
        if (!channel_up) begin
          beat_nx     = 2'd0;
          sof_pend_nx = 1'b0;
          state_nx    = ST_DROP;
          if (head_valid) begin
            pop = 1'b1;
            if (is_end) state_nx = ST_IDLE;
          end
        end
      end
      ST_DROP: begin
        if (head_valid) begin
          pop = 1'b1;
          if (is_end) state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    if (xfer) begin
      sof_pend_nx = 1'b0;
      if (last) begin
        pop     = 1'b1;
        beat_nx = 2'd0;
        if (is_end) state_nx = ST_IDLE;
      end else begin
        beat_nx = beat + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      beat     <= 2'd0;
      sof_pend <= 1'b0;
    end else begin
      state    <= state_nx;
      beat     <= beat_nx;
      sof_pend <= sof_pend_nx;
    end
  end

  assign ll.tx_src_rdy_n = !active;
  assign ll.tx_d         = active ? lane : 16'h0000;
  assign ll.tx_sof_n     = !(active && sof);
  assign ll.tx_eof_n     = !(active && is_end && last);
  assign ll.tx_rem       = active && is_end && last && !end_bytes[0];

`ifdef AUR_TX_STATS_EN
  logic frame_done, abort;
  assign frame_done = xfer && last && is_end;
  assign abort      = (state == ST_SEND) && !channel_up;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_frame_cnt <= 16'd0;
      tx_abort_cnt <= 16'd0;
    end else begin
      if (frame_done) tx_frame_cnt <= tx_frame_cnt + 16'd1;
      if (abort)      tx_abort_cnt <= tx_abort_cnt + 16'd1;
    end
  end
`else
  assign tx_frame_cnt = 16'd0;
  assign tx_abort_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_aur_ll_tx_framer.sv
// Self-checking bench for aur_ll_tx_framer: a scoreboard of expected LocalLink beats is
// filled as packets are written and drained by a monitor on every transfer.
module tb_aur_ll_tx_framer;

  typedef struct {
    logic [15:0] d;
    logic [15:0] m;
    logic        sof;
    logic        eof;
    logic        rem;
  } beat_t;

`ifdef AUR_TX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        channel_up;
  logic [15:0] tx_frame_cnt;
  logic [15:0] tx_abort_cnt;

  aur_ll_tx_dp_if     dp_if ();
  aur_ll_tx_framer_if ll_if ();

  aur_ll_tx_framer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .channel_up   (channel_up),
    .dp           (dp_if),
    .ll           (ll_if),
    .tx_frame_cnt (tx_frame_cnt),
    .tx_abort_cnt (tx_abort_cnt)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  int    xfer_cnt = 0;
  int    exp_frames = 0;
  int    exp_aborts = 0;
  bit    dst_mode = 1'b0;
  beat_t sb[$];

  logic [15:0] prev_d;
  logic        prev_rem, prev_sof, prev_eof;
  bit          prev_stall = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkResetState(input string pre);
    checkOutput({pre, "_src_rdy_n"}, 32'(ll_if.tx_src_rdy_n), 32'd1);
    checkOutput({pre, "_sof_n"}, 32'(ll_if.tx_sof_n), 32'd1);
    checkOutput({pre, "_eof_n"}, 32'(ll_if.tx_eof_n), 32'd1);
    checkOutput({pre, "_tx_d"}, 32'(ll_if.tx_d), 32'd0);
    checkOutput({pre, "_rem"}, 32'(ll_if.tx_rem), 32'd0);
    checkOutput({pre, "_in_rdy"}, 32'(dp_if.in_rdy), 32'd0);
    checkOutput({pre, "_frame_cnt"}, 32'(tx_frame_cnt), 32'd0);
    checkOutput({pre, "_abort_cnt"}, 32'(tx_abort_cnt), 32'd0);
  endtask

  task automatic checkCounters(input string pre);
    checkOutput({pre, "_frame_cnt"}, 32'(tx_frame_cnt), STATS ? 32'(exp_frames) : 32'd0);
    checkOutput({pre, "_abort_cnt"}, 32'(tx_abort_cnt), STATS ? 32'(exp_aborts) : 32'd0);
  endtask

  task automatic writeWord(input logic [63:0] d, input logic [7:0] c);
    int t;
    t = 0;
    while (dp_if.in_rdy !== 1'b1 && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    checkOutput("in_rdy_wait", 32'(dp_if.in_rdy), 32'd1);
    dp_if.in_data = d;
    dp_if.in_ctrl = c;
    dp_if.in_wr   = 1'b1;
    @(posedge clk); #1;
    dp_if.in_wr   = 1'b0;
  endtask

  // Builds a random packet, queues up to exp_beats expected beats, writes up to max_words words.
  task automatic applyStimulus(input bit with_hdr, input int nbytes, input int exp_beats,
                               input int max_words);
    logic [7:0]  pkt[$];
    logic [63:0] w;
    logic [7:0]  c;
    beat_t       b;
    int          nbeats, nwords, r;
    for (int i = 0; i < nbytes; i++) pkt.push_back(8'($urandom));
    nbeats = (nbytes + 1) / 2;
    nwords = (nbytes + 7) / 8;
    for (int k = 0; k < nbeats && k < exp_beats; k++) begin
      b.d[15:8] = pkt[2*k];
      if (2*k + 1 < nbytes) begin
        b.d[7:0] = pkt[2*k+1];
        b.m      = 16'hFFFF;
      end else begin
        b.d[7:0] = 8'h00;
        b.m      = 16'hFF00;
      end
      b.sof = (k == 0);
      b.eof = (k == nbeats - 1);
      b.rem = (nbytes % 2 == 0);
      sb.push_back(b);
    end
    if (with_hdr) writeWord({$urandom, $urandom}, 8'hFF);
    for (int wi = 0; wi < nwords && wi < max_words; wi++) begin
      for (int j = 0; j < 8; j++)
        w[63-8*j -: 8] = (8*wi + j < nbytes) ? pkt[8*wi+j] : 8'h00;
      r = nbytes - 8*wi;
      c = (wi == nwords - 1) ? 8'(1 << (8 - r)) : 8'h00;
      writeWord(w, c);
    end
  endtask

  task automatic waitDrain(input string tag);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 1000) begin
      @(posedge clk);
      t++;
    end
    @(posedge clk); #1;
    checkOutput({tag, "_drain"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic monitorBeat();
    logic [15:0] dv;
    beat_t       b;
    dv = ll_if.tx_d;
    if (reset_n && channel_up && prev_stall) begin
      checkOutput("stall_src_rdy_n", 32'(ll_if.tx_src_rdy_n), 32'd0);
      checkOutput("stall_hold", {13'd0, dv, ll_if.tx_rem, ll_if.tx_sof_n, ll_if.tx_eof_n},
                  {13'd0, prev_d, prev_rem, prev_sof, prev_eof});
    end
    if (reset_n && !ll_if.tx_src_rdy_n && !ll_if.tx_dst_rdy_n) begin
      xfer_cnt++;
      if (sb.size() == 0) begin
        checkOutput("extra_beat_src_rdy_n", 32'(ll_if.tx_src_rdy_n), 32'd1);
      end else begin
        b = sb.pop_front();
        checkOutput("beat_data", 32'(dv & b.m), 32'(b.d & b.m));
        checkOutput("beat_sof", 32'(!ll_if.tx_sof_n), 32'(b.sof));
        checkOutput("beat_eof", 32'(!ll_if.tx_eof_n), 32'(b.eof));
        if (b.eof) checkOutput("beat_rem", 32'(ll_if.tx_rem), 32'(b.rem));
      end
    end
    prev_stall = reset_n && channel_up && !ll_if.tx_src_rdy_n && ll_if.tx_dst_rdy_n;
    prev_d     = dv;
    prev_rem   = ll_if.tx_rem;
    prev_sof   = ll_if.tx_sof_n;
    prev_eof   = ll_if.tx_eof_n;
  endtask

  initial forever begin
    @(negedge clk);
    monitorBeat();
  end

  initial forever begin
    @(posedge clk); #1;
    ll_if.tx_dst_rdy_n = dst_mode ? ~ll_if.tx_dst_rdy_n : 1'b0;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int base;
    int t;
    reset_n            = 1'b0;
    channel_up         = 1'b1;
    ll_if.tx_dst_rdy_n = 1'b0;
    dp_if.in_wr        = 1'b0;
    dp_if.in_data      = '0;
    dp_if.in_ctrl      = '0;

    repeat (3) @(posedge clk);
    #1;
    checkResetState("reset");
    reset_n = 1'b1;
    #1 checkOutput("in_rdy_low_at_release", 32'(dp_if.in_rdy), 32'd0);
    @(posedge clk); #1;
    checkOutput("in_rdy_after_release", 32'(dp_if.in_rdy), 32'd1);

    $display("[TB] channel down: three packets absorbed");
    channel_up = 1'b0;
    applyStimulus(1'b1, 16, 0, 8);
    applyStimulus(1'b0, 9, 0, 8);
    applyStimulus(1'b1, 64, 0, 8);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("down_in_rdy", 32'(dp_if.in_rdy), 32'd1);
    checkCounters("down");
    channel_up = 1'b1;

    $display("[TB] header + 60-byte frame");
    applyStimulus(1'b1, 60, 30, 8);
    waitDrain("hdr60");
    exp_frames++;
    checkCounters("hdr60");

    $display("[TB] 61-byte frame");
    applyStimulus(1'b0, 61, 31, 8);
    waitDrain("b61");
    exp_frames++;
    checkCounters("b61");

    $display("[TB] 1-, 2- and 9-byte frames back to back");
    applyStimulus(1'b0, 1, 1, 1);
    applyStimulus(1'b0, 2, 1, 1);
    applyStimulus(1'b0, 9, 5, 2);
    waitDrain("short");
    exp_frames += 3;
    checkCounters("short");

    $display("[TB] 64-byte frame with dst_rdy_n toggling");
    dst_mode = 1'b1;
    base     = xfer_cnt;
    applyStimulus(1'b0, 64, 32, 8);
    waitDrain("stall");
    checkOutput("stall_xfers", 32'(xfer_cnt - base), 32'd32);
    dst_mode = 1'b0;
    exp_frames++;
    @(posedge clk); #1;

    $display("[TB] channel drop after 10 transfers");
    base = xfer_cnt;
    fork
      applyStimulus(1'b0, 64, 10, 8);
      begin
        t = 0;
        while (xfer_cnt < base + 10 && t < 400) begin
          @(posedge clk);
          t++;
        end
        #1 channel_up = 1'b0;
        #1 checkOutput("abort_src_rdy_n", 32'(ll_if.tx_src_rdy_n), 32'd1);
      end
    join
    repeat (6) @(posedge clk);
    #1;
    exp_aborts++;
    checkOutput("abort_in_rdy", 32'(dp_if.in_rdy), 32'd1);
    checkOutput("abort_sb_empty", 32'(sb.size()), 32'd0);
    checkCounters("abort");
    channel_up = 1'b1;
    applyStimulus(1'b0, 64, 32, 8);
    waitDrain("after_abort");
    exp_frames++;
    checkCounters("after_abort");

    $display("[TB] reset pulsed mid-frame");
    base = xfer_cnt;
    applyStimulus(1'b0, 64, 5, 2);
    t = 0;
    while (xfer_cnt < base + 5 && t < 400) begin
      @(posedge clk);
      t++;
    end
    #1 reset_n = 1'b0;
    sb.delete();
    exp_frames = 0;
    exp_aborts = 0;
    #1 checkResetState("midreset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1 checkOutput("midreset_in_rdy_low", 32'(dp_if.in_rdy), 32'd0);
    @(posedge clk); #1;
    checkOutput("midreset_in_rdy_high", 32'(dp_if.in_rdy), 32'd1);
    applyStimulus(1'b0, 2, 1, 1);
    checkOutput("latency_src_rdy_n", 32'(ll_if.tx_src_rdy_n), 32'd0);
    checkOutput("latency_sof_n", 32'(ll_if.tx_sof_n), 32'd0);
    checkOutput("latency_eof_n", 32'(ll_if.tx_eof_n), 32'd0);
    waitDrain("post_reset");
    exp_frames++;
    checkCounters("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
